// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port.
// Define ARB_ROUND_ROBIN_EN to alternate on ties; otherwise the data port always wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall_if,
    output logic                  stall_d
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              stateQ, stateD;
    logic                winDataQ;
    logic                weQ;
    logic [ADDR_W-1:0]   addrQ;
    logic [DATA_W-1:0]   wdataQ;
    logic [BE_W-1:0]     beQ;
    logic [DATA_W-1:0]   ifRdataQ, dRdataQ;
    logic                grantIf, grantD;
    logic                pickData;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the fetch port was served last; reset value means data served last.
    logic lastIfQ;
    assign pickData = d_req && (!if_req || lastIfQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastIfQ <= 1'b0;
        end else if (grantIf || grantD) begin
            lastIfQ <= grantIf;
        end
    end
`else
    assign pickData = d_req;
`endif

    always_comb begin
        stateD  = stateQ;
        grantIf = 1'b0;
        grantD  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (!rst && (if_req || d_req)) begin
                    stateD  = StBusy;
                    grantD  = pickData;
                    grantIf = !pickData;
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    stateD = StResp;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= StIdle;
            winDataQ <= 1'b0;
            weQ      <= 1'b0;
            addrQ    <= '0;
            wdataQ   <= '0;
            beQ      <= '0;
            ifRdataQ <= '0;
            dRdataQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (grantIf || grantD) begin
                winDataQ <= grantD;
                weQ      <= grantD & d_we;
                addrQ    <= grantD ? d_addr : if_addr;
                wdataQ   <= grantD ? d_wdata : '0;
                beQ      <= grantD ? d_be : '1;
            end
            // Read data lands in the owning port's register, which then holds it.
            if (stateQ == StBusy && mem_ready) begin
                if (winDataQ) begin
                    dRdataQ <= mem_rdata;
                end else begin
                    ifRdataQ <= mem_rdata;
                end
            end
        end
    end

    assign if_gnt    = grantIf;
    assign d_gnt     = grantD;
    assign mem_en    = (stateQ == StBusy);
    assign mem_we    = mem_en & weQ;
    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;
    assign mem_be    = beQ;
    assign if_rvalid = (stateQ == StResp) && !winDataQ;
    assign d_rvalid  = (stateQ == StResp) && winDataQ;
    assign if_rdata  = ifRdataQ;
    assign d_rdata   = dRdataQ;
    assign stall_if  = if_req & ~if_rvalid & ~rst;
    assign stall_d   = d_req & ~d_rvalid & ~rst;

endmodule
